// File: rtl/mod_pkg.sv
// Shared constants for the 2ASK/QPSK modulator chain: PN7 generator
// defaults and the phase_sel encoding understood by the carrier mixer.
package mod_pkg;

    localparam logic [6:0] PN7_TAPS = 7'b1100000;   // x^7 + x^6 + 1
    localparam logic [6:0] PN7_SEED = 7'b1111111;

    localparam logic [1:0] PH_0   = 2'd0;
    localparam logic [1:0] PH_90  = 2'd1;
    localparam logic [1:0] PH_180 = 2'd2;
    localparam logic [1:0] PH_270 = 2'd3;

    // Gray mapping of a dibit onto the carrier phase index.
    function automatic logic [1:0] gray_phase(input logic i_bit, input logic q_bit);
        logic [1:0] ph;
        case ({i_bit, q_bit})
            2'b00:   ph = PH_0;
            2'b01:   ph = PH_90;
            2'b11:   ph = PH_180;
            default: ph = PH_270;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/pn_lfsr.sv
// Fibonacci LFSR with step/load controls. An all-zero state can never
// advance on its own, so a step from zero reloads the seed instead.
module pn_lfsr
    import mod_pkg::*;
#(
    parameter int             W    = 7,
    parameter logic [W-1:0]   TAPS = PN7_TAPS,
    parameter logic [W-1:0]   SEED = PN7_SEED
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic step_i,
    input  logic load_i,
    output logic out_o,
    output logic at_seed_o
);

    logic [W-1:0] lfsr_q;
    logic [W-1:0] lfsr_d;
    logic         fb;

    // Next state: load wins over step; zero state escapes to the seed.
    always_comb begin
        fb     = ^(lfsr_q & TAPS);
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = SEED;
        end else if (step_i) begin
            if (lfsr_q == '0) begin
                lfsr_d = SEED;
            end else begin
                lfsr_d = {lfsr_q[W-2:0], fb};
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign out_o     = lfsr_q[W-1];
    assign at_seed_o = (lfsr_q == SEED);

endmodule

// File: rtl/pn_dibit_source.sv
// PN7 baseband source: one bit per rising edge of the 100 kHz divider
// level, presented as a 2ASK bit and packed in pairs into Gray-coded QPSK
// dibits. A watchdog flags a divider that has stopped toggling.
module pn_dibit_source
    import mod_pkg::*;
#(
    parameter int                  LFSR_W   = 7,
    parameter logic [LFSR_W-1:0]   TAPS     = PN7_TAPS,
    parameter logic [LFSR_W-1:0]   SEED     = PN7_SEED,
    parameter int                  WDOG_MAX = 1023
) (
    input  logic       clk50,
    input  logic       rst,
    input  logic       clk100k,
    input  logic       en,
    input  logic       sync_clr,
    output logic       ask_bit,
    output logic       ask_valid,
    output logic       qpsk_i,
    output logic       qpsk_q,
    output logic [1:0] phase_sel,
    output logic       qpsk_valid,
    output logic       frame_start,
    output logic       clk_lost
);

    localparam int WDOG_W = 10;
    localparam logic [WDOG_W-1:0] WDOG_TOP = WDOG_W'(WDOG_MAX);

    logic              clk100k_q;
    logic              tick;
    logic              lfsr_out;
    logic              lfsr_at_seed;

    logic              half_q,        half_d;
    logic              hold_q,        hold_d;
    logic              ask_bit_q,     ask_bit_d;
    logic              ask_valid_q,   ask_valid_d;
    logic              qpsk_i_q,      qpsk_i_d;
    logic              qpsk_q_q,      qpsk_q_d;
    logic [1:0]        phase_sel_q,   phase_sel_d;
    logic              qpsk_valid_q,  qpsk_valid_d;
    logic              frame_start_q, frame_start_d;
    logic [WDOG_W-1:0] wdog_q,        wdog_d;
    logic              clk_lost_q,    clk_lost_d;

    // The edge register tracks the level even while disabled, so
    // re-enabling with the divider already high does not fake an edge.
    assign tick = clk100k & ~clk100k_q & en;

    pn_lfsr #(
        .W    (LFSR_W),
        .TAPS (TAPS),
        .SEED (SEED)
    ) u_lfsr (
        .clk_i     (clk50),
        .rst_i     (rst),
        .step_i    (tick & ~sync_clr),
        .load_i    (sync_clr),
        .out_o     (lfsr_out),
        .at_seed_o (lfsr_at_seed)
    );

    // Output, pairing and watchdog next-state logic.
    always_comb begin
        half_d        = half_q;
        hold_d        = hold_q;
        ask_bit_d     = ask_bit_q;
        ask_valid_d   = 1'b0;
        qpsk_i_d      = qpsk_i_q;
        qpsk_q_d      = qpsk_q_q;
        phase_sel_d   = phase_sel_q;
        qpsk_valid_d  = 1'b0;
        frame_start_d = 1'b0;

        if (sync_clr) begin
            half_d = 1'b0;
        end else if (tick) begin
            ask_bit_d     = lfsr_out;
            ask_valid_d   = 1'b1;
            frame_start_d = lfsr_at_seed;
            if (!half_q) begin
                hold_d = lfsr_out;
                half_d = 1'b1;
            end else begin
                qpsk_i_d     = hold_q;
                qpsk_q_d     = lfsr_out;
                phase_sel_d  = gray_phase(hold_q, lfsr_out);
                qpsk_valid_d = 1'b1;
                half_d       = 1'b0;
            end
        end

        // Restart the count on sync_clr too, otherwise a saturated
        // counter would re-raise clk_lost on the very next cycle.
        if (!en || tick || sync_clr) begin
            wdog_d = '0;
        end else if (wdog_q != WDOG_TOP) begin
            wdog_d = wdog_q + 1'b1;
        end else begin
            wdog_d = wdog_q;
        end

        clk_lost_d = sync_clr ? 1'b0 : (clk_lost_q | (wdog_d == WDOG_TOP));
    end

    // State registers; the edge register resets high so a divider that is
    // already high at reset release does not produce a tick.
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            clk100k_q     <= 1'b1;
            half_q        <= 1'b0;
            hold_q        <= 1'b0;
            ask_bit_q     <= 1'b0;
            ask_valid_q   <= 1'b0;
            qpsk_i_q      <= 1'b0;
            qpsk_q_q      <= 1'b0;
            phase_sel_q   <= PH_0;
            qpsk_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            wdog_q        <= '0;
            clk_lost_q    <= 1'b0;
        end else begin
            clk100k_q     <= clk100k;
            half_q        <= half_d;
            hold_q        <= hold_d;
            ask_bit_q     <= ask_bit_d;
            ask_valid_q   <= ask_valid_d;
            qpsk_i_q      <= qpsk_i_d;
            qpsk_q_q      <= qpsk_q_d;
            phase_sel_q   <= phase_sel_d;
            qpsk_valid_q  <= qpsk_valid_d;
            frame_start_q <= frame_start_d;
            wdog_q        <= wdog_d;
            clk_lost_q    <= clk_lost_d;
        end
    end

    assign ask_bit     = ask_bit_q;
    assign ask_valid   = ask_valid_q;
    assign qpsk_i      = qpsk_i_q;
    assign qpsk_q      = qpsk_q_q;
    assign phase_sel   = phase_sel_q;
    assign qpsk_valid  = qpsk_valid_q;
    assign frame_start = frame_start_q;
    assign clk_lost    = clk_lost_q;

endmodule

// File: tb/tb_pn_dibit_source.sv
// Scoreboard bench for pn_dibit_source: an independent PN7 model predicts
// every ask/qpsk pulse when a divider edge is driven; a negedge monitor
// pops and compares the bit, frame flag, dibit, phase and arrival cycle.
module tb_pn_dibit_source;

    logic       clk50 = 1'b0;
    logic       rst;
    logic       clk100k;
    logic       en;
    logic       sync_clr;
    logic       ask_bit;
    logic       ask_valid;
    logic       qpsk_i;
    logic       qpsk_q;
    logic [1:0] phase_sel;
    logic       qpsk_valid;
    logic       frame_start;
    logic       clk_lost;

    pn_dibit_source u_dut (
        .clk50       (clk50),
        .rst         (rst),
        .clk100k     (clk100k),
        .en          (en),
        .sync_clr    (sync_clr),
        .ask_bit     (ask_bit),
        .ask_valid   (ask_valid),
        .qpsk_i      (qpsk_i),
        .qpsk_q      (qpsk_q),
        .phase_sel   (phase_sel),
        .qpsk_valid  (qpsk_valid),
        .frame_start (frame_start),
        .clk_lost    (clk_lost)
    );

    always #10 clk50 = ~clk50;

    int unsigned cyc = 0;
    always @(posedge clk50) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic        bit_v;
        logic        fs;
    } ask_exp_t;

    typedef struct {
        int unsigned cyc;
        logic        i_v;
        logic        q_v;
        logic [1:0]  ph;
    } qpsk_exp_t;

    ask_exp_t    ask_sb[$];
    qpsk_exp_t   qpsk_sb[$];
    ask_exp_t    ae;
    qpsk_exp_t   qe;

    logic [6:0]  ref_s;
    logic        ref_half;
    logic        ref_hold;
    logic        ref_last;
    int unsigned last_tick;

    logic        seen_bits[$];
    int unsigned seen_cyc[$];
    int          fs_idx[$];
    logic [1:0]  seen_ph[$];
    logic [1:0]  seen_dib[$];
    int unsigned seen_qcyc[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    endtask

    function automatic logic [1:0] ph_of(input logic i_v, input logic q_v);
        case ({i_v, q_v})
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    // Reference model step for one accepted divider edge.
    task automatic model_tick(input int unsigned stamp);
        logic      out;
        ask_exp_t  an;
        qpsk_exp_t qn;
        out = ref_s[6];
        an.cyc = stamp; an.bit_v = out; an.fs = (ref_s == 7'h7F);
        ask_sb.push_back(an);
        if (ref_s == 7'd0) ref_s = 7'h7F;
        else               ref_s = {ref_s[5:0], ref_s[6] ^ ref_s[5]};
        ref_last  = out;
        last_tick = stamp;
        if (!ref_half) begin
            ref_hold = out;
            ref_half = 1'b1;
        end else begin
            qn.cyc = stamp; qn.i_v = ref_hold; qn.q_v = out; qn.ph = ph_of(ref_hold, out);
            qpsk_sb.push_back(qn);
            ref_half = 1'b0;
        end
    endtask

    // One divider period driven from a negedge: hi cycles high, lo low.
    task automatic period(input int hi, input int lo);
        clk100k = 1'b1;
        if (en && !sync_clr) model_tick(cyc + 1);
        repeat (hi) @(negedge clk50);
        clk100k = 1'b0;
        repeat (lo) @(negedge clk50);
    endtask

    // Output monitor.
    always @(negedge clk50) begin
        if (!rst) begin
            if (ask_valid) begin
                seen_bits.push_back(ask_bit);
                seen_cyc.push_back(cyc);
                if (frame_start) fs_idx.push_back(seen_bits.size());
                if (ask_sb.size() == 0) begin
                    chk("ask_unexpected", 32'(ask_valid), 0);
                end else begin
                    ae = ask_sb.pop_front();
                    chk("ask_bit", 32'(ask_bit), 32'(ae.bit_v));
                    chk("frame_start", 32'(frame_start), 32'(ae.fs));
                    chk("ask_cycle", cyc, ae.cyc);
                end
            end else if (frame_start) begin
                chk("frame_start_stray", 32'(frame_start), 0);
            end
            if (qpsk_valid) begin
                seen_ph.push_back(phase_sel);
                seen_dib.push_back({qpsk_i, qpsk_q});
                seen_qcyc.push_back(cyc);
                if (qpsk_sb.size() == 0) begin
                    chk("qpsk_unexpected", 32'(qpsk_valid), 0);
                end else begin
                    qe = qpsk_sb.pop_front();
                    chk("qpsk_i", 32'(qpsk_i), 32'(qe.i_v));
                    chk("qpsk_q", 32'(qpsk_q), 32'(qe.q_v));
                    chk("phase_sel", 32'(phase_sel), 32'(qe.ph));
                    chk("qpsk_cycle", cyc, qe.cyc);
                end
            end
        end
    end

    logic [7:0] exp8;
    logic [1:0] exp_ph [4];
    logic [1:0] exp_dib[4];

    initial begin
        rst = 1'b1; clk100k = 1'b0; en = 1'b1; sync_clr = 1'b0;
        ref_s = 7'h7F; ref_half = 1'b0; ref_hold = 1'b0; ref_last = 1'b0; last_tick = 0;
        exp8 = 8'b1111_1110;
        exp_ph  = '{2'd2, 2'd2, 2'd2, 2'd3};
        exp_dib = '{2'b11, 2'b11, 2'b11, 2'b10};

        repeat (3) @(negedge clk50);
        chk("rst_ask_bit",     32'(ask_bit), 0);
        chk("rst_ask_valid",   32'(ask_valid), 0);
        chk("rst_qpsk_i",      32'(qpsk_i), 0);
        chk("rst_qpsk_q",      32'(qpsk_q), 0);
        chk("rst_phase_sel",   32'(phase_sel), 0);
        chk("rst_qpsk_valid",  32'(qpsk_valid), 0);
        chk("rst_frame_start", 32'(frame_start), 0);
        chk("rst_clk_lost",    32'(clk_lost), 0);
        chk("rst_lfsr",        32'(u_dut.u_lfsr.lfsr_q), 32'h7F);

        // Divider edge during reset is lost; still high at release -> no tick.
        clk100k = 1'b1;
        repeat (3) @(negedge clk50);
        rst = 1'b0;
        repeat (10) @(negedge clk50);
        clk100k = 1'b0;
        repeat (200) @(negedge clk50);

        // Full PN7 period plus one bit with the nominal divider.
        for (int p = 0; p < 128; p++) period(250, 250);
        @(negedge clk50);
        for (int i = 0; i < 8; i++) chk("pn_first8", 32'(seen_bits[i]), 32'(exp8[7-i]));
        for (int i = 0; i < 4; i++) begin
            chk("dibit_first4", 32'(seen_dib[i]), 32'(exp_dib[i]));
            chk("phase_first4", 32'(seen_ph[i]), 32'(exp_ph[i]));
        end
        chk("frame_count", fs_idx.size(), 2);
        chk("frame_bit1",   fs_idx[0], 1);
        chk("frame_bit128", fs_idx[1], 128);
        chk("ask_spacing",  seen_cyc[1] - seen_cyc[0], 500);
        chk("ask_spacing2", seen_cyc[127] - seen_cyc[126], 500);
        chk("qpsk_spacing", seen_qcyc[1] - seen_qcyc[0], 1000);

        // Long high level gives a single tick.
        period(20, 480);

        // Disabled: three divider edges are ignored.
        en = 1'b0;
        for (int p = 0; p < 3; p++) period(50, 50);
        chk("en_low_lfsr", 32'(u_dut.u_lfsr.lfsr_q), 32'(ref_s));
        chk("en_low_half", 32'(u_dut.half_q), 32'(ref_half));
        en = 1'b1;
        period(250, 250);
        period(250, 250);

        // sync_clr coincident with a tick while half=1.
        if (!ref_half) period(250, 250);
        chk("pre_clr_half", 32'(u_dut.half_q), 1);
        clk100k = 1'b1; sync_clr = 1'b1;
        ref_s = 7'h7F; ref_half = 1'b0;
        @(negedge clk50);
        sync_clr = 1'b0;
        chk("clr_half",     32'(u_dut.half_q), 0);
        chk("clr_lfsr",     32'(u_dut.u_lfsr.lfsr_q), 32'h7F);
        chk("clr_ask_hold", 32'(ask_bit), 32'(ref_last));
        repeat (249) @(negedge clk50);
        clk100k = 1'b0;
        repeat (250) @(negedge clk50);
        for (int p = 0; p < 3; p++) period(250, 250);

        // Watchdog: divider stopped with en=1.
        while (cyc < last_tick + 1000) @(negedge clk50);
        chk("wdog_early", 32'(clk_lost), 0);
        while (cyc < last_tick + 1030) @(negedge clk50);
        chk("wdog_set", 32'(clk_lost), 1);
        period(250, 250);
        period(250, 250);
        chk("wdog_sticky", 32'(clk_lost), 1);
        sync_clr = 1'b1;
        ref_s = 7'h7F; ref_half = 1'b0;
        @(negedge clk50);
        sync_clr = 1'b0;
        chk("wdog_clear", 32'(clk_lost), 0);
        repeat (5) @(negedge clk50);

        // Zero-state escape.
        force u_dut.u_lfsr.lfsr_q = 7'd0;
        @(negedge clk50);
        release u_dut.u_lfsr.lfsr_q;
        ref_s = 7'd0;
        @(negedge clk50);
        period(250, 250);
        chk("zero_bit",    32'(seen_bits[seen_bits.size()-1]), 0);
        chk("zero_reload", 32'(u_dut.u_lfsr.lfsr_q), 32'h7F);
        period(250, 250);

        repeat (5) @(negedge clk50);
        chk("ask_sb_drained",  ask_sb.size(), 0);
        chk("qpsk_sb_drained", qpsk_sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
